// File: rtl/store_fwd_buf_pkg.sv
// Shared constants and helpers for the store buffer with store-to-load forwarding.
package store_fwd_buf_pkg;

   localparam logic        CON_ENABLE = 1'b1;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned DEPTH_DEF  = 4;
   localparam int unsigned ADDR_W_DEF = 14;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned LANES_DEF  = DATA_W_DEF / BYTE_W;

   // Slot holding the k-th youngest store (k=0 is the entry at wr_ptr-1).
   function automatic int unsigned age_slot(input int unsigned wr, input int unsigned k,
                                            input int unsigned depth);
      return (wr + depth - 1 - k) & (depth - 1);
   endfunction

endpackage

// File: rtl/store_fwd_buf_if.sv
// Store, load and DRAM-drain signal bundle of the store buffer.
interface store_fwd_buf_if
   import store_fwd_buf_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic                       st_valid_i;
   logic [ADDR_W-1:0]          st_adr_i;
   logic [DATA_W-1:0]          st_wd_i;
   logic [DATA_W/8-1:0]        st_be_i;
   logic                       st_ready_o;
   logic                       ld_valid_i;
   logic [ADDR_W-1:0]          ld_adr_i;
   logic [DATA_W-1:0]          ld_rd_i;
   logic [DATA_W-1:0]          ld_rd_o;
   logic                       ld_fwd_o;
   logic                       dram_busy_i;
   logic                       dram_we_o;
   logic [ADDR_W-1:0]          dram_adr_o;
   logic [DATA_W-1:0]          dram_wd_o;
   logic [DATA_W/8-1:0]        dram_be_o;
   logic [$clog2(DEPTH+1)-1:0] count_o;
   logic                       empty_o;

   modport slave (
      input  st_valid_i, st_adr_i, st_wd_i, st_be_i,
      input  ld_valid_i, ld_adr_i, ld_rd_i, dram_busy_i,
      output st_ready_o, ld_rd_o, ld_fwd_o,
      output dram_we_o, dram_adr_o, dram_wd_o, dram_be_o, count_o, empty_o
   );

   modport master (
      output st_valid_i, st_adr_i, st_wd_i, st_be_i,
      output ld_valid_i, ld_adr_i, ld_rd_i, dram_busy_i,
      input  st_ready_o, ld_rd_o, ld_fwd_o,
      input  dram_we_o, dram_adr_o, dram_wd_o, dram_be_o, count_o, empty_o
   );

endinterface

// File: rtl/store_fwd_buf_lane_sel.sv
// Per-byte-lane age-priority select: same-cycle bypass first, then youngest buffered match.
module sfb_lane_sel
   import store_fwd_buf_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic              byp_hit,
   input  logic [BYTE_W-1:0] byp_byte,
   input  logic [DEPTH-1:0]  match,
   input  logic [BYTE_W-1:0] cand [DEPTH],
   input  logic [BYTE_W-1:0] raw_byte,
   output logic [BYTE_W-1:0] lane_byte,
   output logic              hit
);

   // match/cand index 0 is the youngest entry; the first hit wins.
   always_comb begin
      lane_byte = raw_byte;
      hit       = 1'b0;
      if (byp_hit) begin
         lane_byte = byp_byte;
         hit       = 1'b1;
      end
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (!hit && match[k]) begin
            lane_byte = cand[k];
            hit       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/store_fwd_buf.sv
// Multi-entry store buffer draining to DRAM with byte-lane store-to-load forwarding.
// Optional macro STORE_BYPASS_EN: a store accepted this cycle also forwards to a same-cycle load.
module store_fwd_buf
   import store_fwd_buf_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   store_fwd_buf_if.slave  bus
);

   localparam int unsigned LN = DATA_W / BYTE_W;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] e_adr [DEPTH];
   logic [DATA_W-1:0] e_wd  [DEPTH];
   logic [LN-1:0]     e_be  [DEPTH];
   logic [DEPTH-1:0]  e_vld;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;

   logic st_ready, push, drain;

   assign st_ready = (count != CW'(DEPTH));
   assign push     = bus.st_valid_i && st_ready && (bus.st_be_i != '0);
   assign drain    = (count != '0) && !bus.dram_busy_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         e_vld  <= '0;
      end else begin
         if (drain) begin
            e_vld[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + PW'(1);
         end
         if (push) begin
            e_vld[wr_ptr] <= CON_ENABLE;
            wr_ptr        <= wr_ptr + PW'(1);
         end
         if (push && !drain)
            count <= count + CW'(1);
         else if (drain && !push)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         e_adr[wr_ptr] <= bus.st_adr_i;
         e_wd[wr_ptr]  <= bus.st_wd_i;
         e_be[wr_ptr]  <= bus.st_be_i;
      end
   end

   always_comb begin
      bus.dram_we_o  = drain;
      bus.dram_adr_o = '0;
      bus.dram_wd_o  = '0;
      bus.dram_be_o  = '0;
      if (count != '0) begin
         bus.dram_adr_o = e_adr[rd_ptr];
         bus.dram_wd_o  = e_wd[rd_ptr];
         bus.dram_be_o  = e_be[rd_ptr];
      end
   end

   assign bus.st_ready_o = st_ready;
   assign bus.count_o    = count;
   assign bus.empty_o    = (count == '0);

   logic [PW-1:0]     slot [DEPTH];
   logic [DEPTH-1:0]  lane_match [LN];
   logic [BYTE_W-1:0] lane_cand [LN][DEPTH];
   logic [LN-1:0]     byp_hit;
   logic [LN-1:0]     lane_hit;
   logic [DATA_W-1:0] ld_rd;

   // Re-order entries youngest-first so each lane selector sees age order directly.
   always_comb begin
      for (int unsigned k = 0; k < DEPTH; k++)
         slot[k] = PW'(age_slot(32'(wr_ptr), k, DEPTH));
      for (int unsigned b = 0; b < LN; b++) begin
         lane_match[b] = '0;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            lane_match[b][k] = bus.ld_valid_i && e_vld[slot[k]] &&
                               (e_adr[slot[k]] == bus.ld_adr_i) && e_be[slot[k]][b];
            lane_cand[b][k]  = e_wd[slot[k]][b*BYTE_W +: BYTE_W];
         end
      end
   end

   always_comb begin
      byp_hit = '0;
`ifdef STORE_BYPASS_EN
      for (int unsigned b = 0; b < LN; b++)
         byp_hit[b] = bus.ld_valid_i && bus.st_valid_i && st_ready &&
                      (bus.st_adr_i == bus.ld_adr_i) && bus.st_be_i[b];
`else
      byp_hit = '0;
`endif
   end

   for (genvar b = 0; b < LN; b++) begin : g_lane
      sfb_lane_sel #(.DEPTH(DEPTH)) u_sel (
         .byp_hit   (byp_hit[b]),
         .byp_byte  (bus.st_wd_i[b*BYTE_W +: BYTE_W]),
         .match     (lane_match[b]),
         .cand      (lane_cand[b]),
         .raw_byte  (bus.ld_rd_i[b*BYTE_W +: BYTE_W]),
         .lane_byte (ld_rd[b*BYTE_W +: BYTE_W]),
         .hit       (lane_hit[b])
      );
   end

   assign bus.ld_rd_o  = ld_rd;
   assign bus.ld_fwd_o = |lane_hit;

endmodule

// File: tb/tb_store_fwd_buf.sv
// Directed self-checking bench for store_fwd_buf (DEPTH=4, ADDR_W=14, DATA_W=32).
module tb_store_fwd_buf;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   store_fwd_buf_if #(.DEPTH(4), .ADDR_W(14), .DATA_W(32)) bus ();

   store_fwd_buf #(.DEPTH(4), .ADDR_W(14), .DATA_W(32)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.st_valid_i = 1'b0;
      bus.st_adr_i   = '0;
      bus.st_wd_i    = '0;
      bus.st_be_i    = '0;
      bus.ld_valid_i = 1'b0;
      bus.ld_adr_i   = '0;
      bus.ld_rd_i    = '0;
   endtask

   task automatic push_in(input logic [13:0] adr, input logic [31:0] wd, input logic [3:0] be);
      bus.st_valid_i = 1'b1;
      bus.st_adr_i   = adr;
      bus.st_wd_i    = wd;
      bus.st_be_i    = be;
   endtask

   task automatic load_in(input logic [13:0] adr, input logic [31:0] rd);
      bus.ld_valid_i = 1'b1;
      bus.ld_adr_i   = adr;
      bus.ld_rd_i    = rd;
   endtask

   task automatic test_reset();
      idle();
      bus.dram_busy_i = 1'b0;
      load_in(14'h010, 32'hDEADBEEF);
      #3;
      checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", bus.count_o); end
      checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b exp 1", bus.empty_o); end
      checks++; if (bus.st_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", bus.st_ready_o); end
      checks++; if ({bus.dram_we_o, bus.dram_adr_o, bus.dram_wd_o, bus.dram_be_o} !== 51'd0) begin errors++; $display("FAIL rst_dram: got we=%b adr=%h wd=%h be=%h exp all 0", bus.dram_we_o, bus.dram_adr_o, bus.dram_wd_o, bus.dram_be_o); end
      checks++; if (bus.ld_rd_o !== 32'hDEADBEEF || bus.ld_fwd_o !== 1'b0) begin errors++; $display("FAIL rst_ld: got %h/%b exp DEADBEEF/0", bus.ld_rd_o, bus.ld_fwd_o); end
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      idle();
   endtask

   task automatic test_reset_mid_drain();
      bus.dram_busy_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_in(14'(32'h001 + i), 32'h0C00_0000 + i, 4'hF);
         cyc();
      end
      idle();
      bus.dram_busy_i = 1'b0;
      #2;
      checks++; if (bus.count_o !== 3'd3 || bus.dram_we_o !== 1'b1 || bus.dram_adr_o !== 14'h001) begin errors++; $display("FAIL mid_pre: got cnt=%0d we=%b adr=%h exp 3/1/001", bus.count_o, bus.dram_we_o, bus.dram_adr_o); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.count_o !== 3'd0 || bus.dram_we_o !== 1'b0 || bus.empty_o !== 1'b1) begin errors++; $display("FAIL mid_rst: got cnt=%0d we=%b empty=%b exp 0/0/1", bus.count_o, bus.dram_we_o, bus.empty_o); end
      @(posedge clk);
      #4;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++; if (bus.dram_we_o !== 1'b0 || bus.count_o !== 3'd0) begin errors++; $display("FAIL mid_stale: cycle %0d got we=%b cnt=%0d exp 0/0", i, bus.dram_we_o, bus.count_o); end
      end
   endtask

   task automatic test_single_fwd();
      bus.dram_busy_i = 1'b1;
      push_in(14'h010, 32'hAABBCCDD, 4'hF);
      cyc();
      idle();
      load_in(14'h010, 32'h0);
      #2;
      checks++; if (bus.ld_rd_o !== 32'hAABBCCDD || bus.ld_fwd_o !== 1'b1) begin errors++; $display("FAIL fwd_full: got %h/%b exp AABBCCDD/1", bus.ld_rd_o, bus.ld_fwd_o); end
      checks++; if (bus.count_o !== 3'd1 || bus.dram_we_o !== 1'b0) begin errors++; $display("FAIL fwd_cnt: got cnt=%0d we=%b exp 1/0", bus.count_o, bus.dram_we_o); end
      bus.ld_valid_i = 1'b0;
      bus.ld_rd_i    = 32'h5A5A5A5A;
      #1;
      checks++; if (bus.ld_rd_o !== 32'h5A5A5A5A || bus.ld_fwd_o !== 1'b0) begin errors++; $display("FAIL fwd_novalid: got %h/%b exp 5A5A5A5A/0", bus.ld_rd_o, bus.ld_fwd_o); end
      cyc();
   endtask

   task automatic test_merge();
      idle();
      push_in(14'h020, 32'h11111111, 4'hF);
      cyc();
      push_in(14'h020, 32'h000000FF, 4'h1);
      cyc();
      idle();
      load_in(14'h020, 32'h0);
      #2;
      checks++; if (bus.ld_rd_o !== 32'h111111FF || bus.ld_fwd_o !== 1'b1) begin errors++; $display("FAIL merge_young: got %h/%b exp 111111FF/1", bus.ld_rd_o, bus.ld_fwd_o); end
      load_in(14'h024, 32'h12345678);
      #1;
      checks++; if (bus.ld_rd_o !== 32'h12345678 || bus.ld_fwd_o !== 1'b0) begin errors++; $display("FAIL merge_miss: got %h/%b exp 12345678/0", bus.ld_rd_o, bus.ld_fwd_o); end
      cyc();
      idle();
      push_in(14'h020, 32'hFFFFFFFF, 4'h0);
      cyc();
      idle();
      load_in(14'h020, 32'h0);
      #2;
      checks++; if (bus.count_o !== 3'd3 || bus.ld_rd_o !== 32'h111111FF) begin errors++; $display("FAIL be_zero: got cnt=%0d ld=%h exp 3/111111FF", bus.count_o, bus.ld_rd_o); end
      idle();
      bus.dram_busy_i = 1'b0;
      #1;
      checks++; if ({bus.dram_we_o, bus.dram_adr_o, bus.dram_wd_o, bus.dram_be_o} !== {1'b1, 14'h010, 32'hAABBCCDD, 4'hF}) begin errors++; $display("FAIL drain0: got we=%b adr=%h wd=%h be=%h exp 1/010/AABBCCDD/F", bus.dram_we_o, bus.dram_adr_o, bus.dram_wd_o, bus.dram_be_o); end
      cyc();
      #2;
      checks++; if ({bus.dram_we_o, bus.dram_adr_o, bus.dram_wd_o, bus.dram_be_o} !== {1'b1, 14'h020, 32'h11111111, 4'hF}) begin errors++; $display("FAIL drain1: got we=%b adr=%h wd=%h be=%h exp 1/020/11111111/F", bus.dram_we_o, bus.dram_adr_o, bus.dram_wd_o, bus.dram_be_o); end
      cyc();
      #2;
      checks++; if ({bus.dram_we_o, bus.dram_adr_o, bus.dram_wd_o, bus.dram_be_o} !== {1'b1, 14'h020, 32'h000000FF, 4'h1}) begin errors++; $display("FAIL drain2: got we=%b adr=%h wd=%h be=%h exp 1/020/000000FF/1", bus.dram_we_o, bus.dram_adr_o, bus.dram_wd_o, bus.dram_be_o); end
      cyc();
      #2;
      checks++; if (bus.empty_o !== 1'b1 || {bus.dram_we_o, bus.dram_adr_o, bus.dram_wd_o, bus.dram_be_o} !== 51'd0) begin errors++; $display("FAIL drain_empty: got empty=%b we=%b adr=%h wd=%h exp 1/0/0/0", bus.empty_o, bus.dram_we_o, bus.dram_adr_o, bus.dram_wd_o); end
   endtask

   task automatic test_full_wrap();
      idle();
      bus.dram_busy_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_in(14'(32'h040 + i), 32'hA000_0000 + i, 4'hF);
         cyc();
      end
      idle();
      load_in(14'h041, 32'h0);
      #2;
      checks++; if (bus.count_o !== 3'd4 || bus.st_ready_o !== 1'b0 || bus.dram_we_o !== 1'b0) begin errors++; $display("FAIL full: got cnt=%0d rdy=%b we=%b exp 4/0/0", bus.count_o, bus.st_ready_o, bus.dram_we_o); end
      checks++; if (bus.ld_rd_o !== 32'hA0000001 || bus.ld_fwd_o !== 1'b1) begin errors++; $display("FAIL full_fwd: got %h/%b exp A0000001/1", bus.ld_rd_o, bus.ld_fwd_o); end
      idle();
      bus.dram_busy_i = 1'b0;
      push_in(14'h050, 32'h00000055, 4'hF);
      #1;
      checks++; if (bus.st_ready_o !== 1'b0 || bus.dram_we_o !== 1'b1 || bus.dram_adr_o !== 14'h040 || bus.dram_wd_o !== 32'hA0000000) begin errors++; $display("FAIL full_drain0: got rdy=%b we=%b adr=%h wd=%h exp 0/1/040/A0000000", bus.st_ready_o, bus.dram_we_o, bus.dram_adr_o, bus.dram_wd_o); end
      cyc();
      #2;
      checks++; if (bus.count_o !== 3'd3 || bus.st_ready_o !== 1'b1 || bus.dram_adr_o !== 14'h041) begin errors++; $display("FAIL full_retry: got cnt=%0d rdy=%b adr=%h exp 3/1/041", bus.count_o, bus.st_ready_o, bus.dram_adr_o); end
      cyc();
      idle();
      load_in(14'h050, 32'h0);
      #2;
      checks++; if (bus.count_o !== 3'd3 || bus.dram_adr_o !== 14'h042) begin errors++; $display("FAIL wrap_d2: got cnt=%0d adr=%h exp 3/042", bus.count_o, bus.dram_adr_o); end
      checks++; if (bus.ld_rd_o !== 32'h00000055 || bus.ld_fwd_o !== 1'b1) begin errors++; $display("FAIL wrap_fwd: got %h/%b exp 00000055/1", bus.ld_rd_o, bus.ld_fwd_o); end
      cyc();
      idle();
      #2;
      checks++; if (bus.count_o !== 3'd2 || bus.dram_adr_o !== 14'h043 || bus.dram_wd_o !== 32'hA0000003) begin errors++; $display("FAIL wrap_d3: got cnt=%0d adr=%h wd=%h exp 2/043/A0000003", bus.count_o, bus.dram_adr_o, bus.dram_wd_o); end
      cyc();
      #2;
      checks++; if (bus.count_o !== 3'd1 || bus.dram_adr_o !== 14'h050 || bus.dram_wd_o !== 32'h00000055) begin errors++; $display("FAIL wrap_d4: got cnt=%0d adr=%h wd=%h exp 1/050/00000055", bus.count_o, bus.dram_adr_o, bus.dram_wd_o); end
      cyc();
      #2;
      checks++; if (bus.count_o !== 3'd0 || bus.empty_o !== 1'b1 || bus.dram_we_o !== 1'b0) begin errors++; $display("FAIL wrap_empty: got cnt=%0d empty=%b we=%b exp 0/1/0", bus.count_o, bus.empty_o, bus.dram_we_o); end
   endtask

   task automatic test_back_to_back();
      idle();
      bus.dram_busy_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         push_in(14'(32'h060 + i), 32'h0000_00B0 + i, 4'hF);
         #2;
         if (i == 0) begin
            checks++; if (bus.count_o !== 3'd0 || bus.dram_we_o !== 1'b0) begin errors++; $display("FAIL b2b_first: got cnt=%0d we=%b exp 0/0", bus.count_o, bus.dram_we_o); end
         end else begin
            checks++; if (bus.count_o !== 3'd1 || bus.dram_we_o !== 1'b1 || bus.dram_adr_o !== 14'(32'h060 + i - 1) || bus.dram_wd_o !== 32'h0000_00B0 + i - 1) begin errors++; $display("FAIL b2b_%0d: got cnt=%0d we=%b adr=%h wd=%h exp 1/1/%h/%h", i, bus.count_o, bus.dram_we_o, bus.dram_adr_o, bus.dram_wd_o, 14'(32'h060 + i - 1), 32'h0000_00B0 + i - 1); end
         end
         cyc();
      end
      idle();
      #2;
      checks++; if (bus.count_o !== 3'd1 || bus.dram_adr_o !== 14'h069 || bus.dram_wd_o !== 32'h000000B9) begin errors++; $display("FAIL b2b_last: got cnt=%0d adr=%h wd=%h exp 1/069/000000B9", bus.count_o, bus.dram_adr_o, bus.dram_wd_o); end
      cyc();
      #2;
      checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b exp 1", bus.empty_o); end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_same;
      logic [31:0] exp_prio;
`ifdef STORE_BYPASS_EN
      exp_same = 32'h0000AB00;
      exp_prio = 32'h0000CD00;
`else
      exp_same = 32'h00000000;
      exp_prio = 32'h0000AB00;
`endif
      idle();
      bus.dram_busy_i = 1'b1;
      push_in(14'h030, 32'h0000AB00, 4'b0010);
      load_in(14'h030, 32'h0);
      #2;
      checks++; if (bus.ld_rd_o !== exp_same) begin errors++; $display("FAIL byp_same: got %h exp %h", bus.ld_rd_o, exp_same); end
      cyc();
      idle();
      load_in(14'h030, 32'h0);
      #2;
      checks++; if (bus.ld_rd_o !== 32'h0000AB00 || bus.ld_fwd_o !== 1'b1) begin errors++; $display("FAIL byp_next: got %h/%b exp 0000AB00/1", bus.ld_rd_o, bus.ld_fwd_o); end
      push_in(14'h030, 32'h0000CD00, 4'b0010);
      #1;
      checks++; if (bus.ld_rd_o !== exp_prio) begin errors++; $display("FAIL byp_prio: got %h exp %h", bus.ld_rd_o, exp_prio); end
      cyc();
      idle();
      bus.dram_busy_i = 1'b0;
      cyc();
      cyc();
      #2;
      checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL byp_drain: got empty=%b exp 1", bus.empty_o); end
   endtask

   initial begin
      test_reset();
      test_reset_mid_drain();
      test_single_fwd();
      test_merge();
      test_full_wrap();
      test_back_to_back();
      test_bypass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
